// File: rtl/morra_match_driver_if.sv
// morra_match_driver_if: control, move-load and game-arbiter signals of morra_match_driver.
// master drives commands, moves and arbiter verdicts; slave is the driver itself.
interface morra_match_driver_if;
  logic go, abort, ld_valid, ld_ready, START, busy, done, timeout;
  logic [1:0] ld_p1, ld_p2, P1, P2, ROUND, GAME, result;
  logic [3:0] level, p1_wins, p2_wins, ties, voids;
  modport master (
    output go, abort, ld_valid, ld_p1, ld_p2, ROUND, GAME,
    input ld_ready, START, P1, P2, busy, done, result, timeout, level,
    input p1_wins, p2_wins, ties, voids
  );
  modport slave (
    input go, abort, ld_valid, ld_p1, ld_p2, ROUND, GAME,
    output ld_ready, START, P1, P2, busy, done, result, timeout, level,
    output p1_wins, p2_wins, ties, voids
  );
endinterface

// File: rtl/morra_match_driver.sv
// morra_match_driver: sequences a Morra match from an 8-deep move-pair FIFO into a game arbiter.
// Define MORRA_DRV_TIMEOUT_EN to end a match with timeout=1 after 255 busy cycles.
module morra_match_driver (
  input logic clk,
  input logic rst_n,
  morra_match_driver_if.slave bus
);
  typedef enum logic [2:0] {IDLE, STRT, SETUP, PLAY, WAIT, EVAL, DONE} state_t;
  state_t state_q;
  logic [3:0] mem_q [8];
  logic [2:0] wr_q, rd_q;
  logic [3:0] cnt_q, head;
  logic start_q, busy_q, done_q, timeout_q;
  logic [1:0] p1_q, p2_q, result_q;
  logic [3:0] p1w_q, p2w_q, tie_q, void_q;
  logic push, pop, tmo, fin;
  function automatic logic [3:0] sat(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction
  assign push = bus.ld_valid && !cnt_q[3];
  assign pop  = (state_q == SETUP || state_q == PLAY) && cnt_q != 4'd0 && !bus.abort;
  assign head = mem_q[rd_q];
  assign fin  = bus.GAME != 2'b00;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {bus.ld_p1, bus.ld_p2};
  // pop only reads the registered count, so a pair pushed this cycle is never popped this cycle
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + 3'(push);
      rd_q <= rd_q + 3'(pop);
      cnt_q <= cnt_q + 4'(push) - 4'(pop);
    end
`ifdef MORRA_DRV_TIMEOUT_EN
  logic [7:0] tcnt_q;
  always_ff @(posedge clk)
    if (!rst_n || state_q == IDLE || state_q == STRT) tcnt_q <= '0;
    else if (busy_q && tcnt_q != 8'hff) tcnt_q <= tcnt_q + 8'd1;
  assign tmo = tcnt_q == 8'hff && state_q != DONE && !(state_q == EVAL && fin);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      {p1_q, p2_q} <= '0;
      result_q <= '0;
      {p1w_q, p2w_q, tie_q, void_q} <= '0;
    end else if (bus.abort && state_q != IDLE) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      {p1_q, p2_q} <= '0;
    end else if (tmo) begin
      state_q <= DONE;
      done_q <= 1'b1;
      timeout_q <= 1'b1;
      result_q <= 2'b00;
      {p1_q, p2_q} <= '0;
    end else
      case (state_q)
        IDLE: if (bus.go && !bus.abort) begin
          state_q <= STRT;
          start_q <= 1'b1;
          busy_q <= 1'b1;
          timeout_q <= 1'b0;
          result_q <= '0;
          {p1w_q, p2w_q, tie_q, void_q} <= '0;
        end
        STRT: begin
          state_q <= SETUP;
          start_q <= 1'b0;
        end
        SETUP: if (pop) begin
          state_q <= PLAY;
          {p1_q, p2_q} <= head;
        end
        PLAY: begin
          state_q <= pop ? WAIT : PLAY;
          {p1_q, p2_q} <= pop ? head : 4'b0000;
        end
        WAIT: state_q <= EVAL;
        EVAL: begin
          p1w_q <= bus.ROUND == 2'b01 ? sat(p1w_q) : p1w_q;
          p2w_q <= bus.ROUND == 2'b10 ? sat(p2w_q) : p2w_q;
          tie_q <= bus.ROUND == 2'b11 ? sat(tie_q) : tie_q;
          void_q <= bus.ROUND == 2'b00 ? sat(void_q) : void_q;
          state_q <= fin ? DONE : PLAY;
          done_q <= fin;
          result_q <= fin ? bus.GAME : result_q;
          {p1_q, p2_q} <= '0;
        end
        DONE: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
  assign bus.ld_ready = !cnt_q[3];
  assign bus.level = cnt_q;
  assign bus.START = start_q;
  assign bus.P1 = p1_q;
  assign bus.P2 = p2_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.result = result_q;
  assign bus.timeout = timeout_q;
  assign bus.p1_wins = p1w_q;
  assign bus.p2_wins = p2w_q;
  assign bus.ties = tie_q;
  assign bus.voids = void_q;
endmodule

// File: tb/tb_morra_match_driver.sv
// tb_morra_match_driver: directed checks of morra_match_driver; inputs change and outputs are sampled on negedge.
module tb_morra_match_driver;
  logic clk, rst_n;
  int errors, checks;
  morra_match_driver_if bus();
  morra_match_driver dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [3:0] v);
    bus.ld_valid = 1'b1;
    {bus.ld_p1, bus.ld_p2} = v;
    cyc(1);
  endtask
  initial begin
    clk = 0; rst_n = 0; errors = 0; checks = 0;
    bus.go = 0; bus.abort = 0; bus.ld_valid = 0; bus.ld_p1 = 0; bus.ld_p2 = 0;
    bus.ROUND = 0; bus.GAME = 0;
    cyc(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_start", bus.START, 0);
    chk("rst_pair", {bus.P1, bus.P2}, 0);
    chk("rst_done", bus.done, 0);
    rst_n = 1;
    cyc(1);
    chk("ready_after_rst", bus.ld_ready, 1);
    // FIFO fill to 8 with a 9th pending, then pop frees a slot; abort in WAIT
    for (int i = 0; i < 8; i++) push(4'(i + 3));
    {bus.ld_p1, bus.ld_p2} = 4'b1100;
    chk("full_level", bus.level, 8);
    chk("full_ready", bus.ld_ready, 0);
    cyc(1);
    chk("full_refuse", bus.level, 8);
    bus.go = 1;
    cyc(1);
    bus.go = 0;
    chk("strt_start", bus.START, 1);
    chk("strt_busy", bus.busy, 1);
    cyc(1);
    chk("setup_start", bus.START, 0);
    chk("setup_ready", bus.ld_ready, 0);
    cyc(1);
    chk("pop1_level", bus.level, 7);
    chk("pop1_ready", bus.ld_ready, 1);
    chk("setup_word", {bus.P1, bus.P2}, 4'b0011);
    cyc(1);
    chk("pushpop_level", bus.level, 7);
    chk("wait_pair", {bus.P1, bus.P2}, 4'b0100);
    bus.ld_valid = 0;
    bus.abort = 1;
    cyc(1);
    bus.abort = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_level", bus.level, 7);
    bus.go = 1; bus.abort = 1;
    cyc(1);
    bus.go = 0; bus.abort = 0;
    chk("goabort_busy", bus.busy, 0);
    chk("goabort_start", bus.START, 0);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    chk("rst2_level", bus.level, 0);
    // full three-round match ending on GAME=10
    push(4'b0101); push(4'b0111); push(4'b1011); push(4'b1111);
    bus.ld_valid = 0;
    chk("m_level4", bus.level, 4);
    bus.go = 1;
    cyc(1);
    bus.go = 0;
    chk("m_start", bus.START, 1);
    chk("m_strt_pair", {bus.P1, bus.P2}, 0);
    cyc(1);
    chk("m_start_low", bus.START, 0);
    cyc(1);
    chk("m_setup_word", {bus.P1, bus.P2}, 4'b0101);
    cyc(1);
    chk("m_r1_wait", {bus.P1, bus.P2}, 4'b0111);
    cyc(1);
    chk("m_r1_eval", {bus.P1, bus.P2}, 4'b0111);
    bus.ROUND = 2'b01;
    cyc(1);
    chk("m_p1w", bus.p1_wins, 1);
    cyc(1);
    chk("m_r2_wait", {bus.P1, bus.P2}, 4'b1011);
    cyc(1);
    bus.ROUND = 2'b10;
    cyc(1);
    chk("m_p2w", bus.p2_wins, 1);
    cyc(1);
    chk("m_r3_wait", {bus.P1, bus.P2}, 4'b1111);
    chk("m_level0", bus.level, 0);
    cyc(1);
    bus.ROUND = 2'b11; bus.GAME = 2'b10;
    cyc(1);
    bus.ROUND = 2'b00; bus.GAME = 2'b00;
    chk("m_done", bus.done, 1);
    chk("m_result", bus.result, 2);
    chk("m_tallies", {bus.p1_wins, bus.p2_wins}, 8'h11);
    chk("m_ties_voids", {bus.ties, bus.voids}, 8'h10);
    chk("m_done_pair", {bus.P1, bus.P2}, 0);
    cyc(1);
    chk("m_done_pulse", bus.done, 0);
    chk("m_idle_busy", bus.busy, 0);
    chk("m_result_hold", bus.result, 2);
    // empty FIFO stalls in SETUP and PLAY; no same-cycle bypass
    bus.go = 1;
    cyc(1);
    bus.go = 0;
    cyc(1);
    chk("e_setup_pair", {bus.P1, bus.P2}, 0);
    chk("e_tally_clr", bus.p1_wins, 0);
    push(4'b0110);
    bus.ld_valid = 0;
    chk("e_nobypass_pair", {bus.P1, bus.P2}, 0);
    chk("e_nobypass_level", bus.level, 1);
    cyc(1);
    chk("e_setup_word", {bus.P1, bus.P2}, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("e_play_idle", {bus.P1, bus.P2}, 0);
    end
    push(4'b1001);
    bus.ld_valid = 0;
    chk("e_play_push", {bus.P1, bus.P2}, 0);
    cyc(1);
    chk("e_wait_pair", {bus.P1, bus.P2}, 4'b1001);
    cyc(1);
    chk("e_eval_pair", {bus.P1, bus.P2}, 4'b1001);
    bus.ROUND = 2'b00; bus.GAME = 2'b11;
    cyc(1);
    bus.GAME = 2'b00;
    chk("e_done", bus.done, 1);
    chk("e_voids", bus.voids, 1);
    chk("e_result", bus.result, 3);
    cyc(1);
    // tally saturation: more than 15 P1 wins in one match
    bus.ld_valid = 1; {bus.ld_p1, bus.ld_p2} = 4'b0101; bus.ROUND = 2'b01;
    bus.go = 1;
    cyc(1);
    bus.go = 0;
    cyc(70);
    bus.GAME = 2'b01;
    for (int i = 0; i < 10 && !bus.done; i++) cyc(1);
    bus.GAME = 2'b00; bus.ld_valid = 0; bus.ROUND = 2'b00;
    chk("s_done", bus.done, 1);
    chk("s_p1_sat", bus.p1_wins, 15);
    chk("s_p2", bus.p2_wins, 0);
    chk("s_result", bus.result, 1);
    cyc(1);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    // reset in EVAL with level 3 overrides go and abort
    for (int i = 1; i <= 6; i++) push(4'(i));
    bus.ld_valid = 0;
    bus.go = 1;
    cyc(1);
    bus.go = 0;
    cyc(4);
    bus.ROUND = 2'b01;
    cyc(3);
    bus.ROUND = 2'b00;
    chk("r_eval_level", bus.level, 3);
    chk("r_eval_pair", {bus.P1, bus.P2}, 4'b0011);
    chk("r_eval_p1w", bus.p1_wins, 1);
    rst_n = 0; bus.go = 1; bus.abort = 1;
    cyc(1);
    chk("r_busy", bus.busy, 0);
    chk("r_done", bus.done, 0);
    chk("r_pair", {bus.P1, bus.P2}, 0);
    chk("r_level", bus.level, 0);
    chk("r_p1w", bus.p1_wins, 0);
    chk("r_res_tmo", {bus.result, bus.timeout, bus.START}, 0);
    rst_n = 1; bus.go = 0; bus.abort = 0;
    cyc(1);
    chk("r_ready", bus.ld_ready, 1);
    chk("r_idle", bus.busy, 0);
    // stuck GAME with an empty FIFO
    bus.go = 1;
    cyc(1);
    bus.go = 0;
`ifdef MORRA_DRV_TIMEOUT_EN
    for (int i = 0; i < 300 && !bus.done; i++) cyc(1);
    chk("t_done", bus.done, 1);
    chk("t_timeout", bus.timeout, 1);
    chk("t_result", bus.result, 0);
`else
    begin
      logic seen;
      seen = 0;
      repeat (300) begin
        cyc(1);
        if (bus.done) seen = 1;
      end
      chk("t_no_done", seen, 0);
      chk("t_no_timeout", bus.timeout, 0);
      chk("t_still_busy", bus.busy, 1);
    end
`endif
    bus.abort = 1;
    cyc(1);
    bus.abort = 0;
    chk("t_end_idle", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
